// File: rtl/sw_io_pkg.sv
// Shared definitions for the slide-switch input path: switch count, the
// debounce FSM states and the Up/Down/UnChange codes the scan stage reports.
package sw_io_pkg;

  // Number of board slide switches.
  localparam int unsigned N_SW_DEFAULT = 10;

  // Debounce/hold controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sw_state_e;

  // Per-bit change code consumed by the switch-scan stage.
  typedef enum logic [1:0] {
    SW_DOWN     = 2'd0,
    SW_UP       = 2'd1,
    SW_UNCHANGE = 2'd2
  } sw_change_e;

  // Classify one bit from its history value and its current stable value.
  function automatic sw_change_e sw_change_code(input logic hist_bit,
                                                input logic sw_bit);
    sw_change_e code;
    if (hist_bit == sw_bit) begin
      code = SW_UNCHANGE;
    end else if (sw_bit) begin
      code = SW_UP;
    end else begin
      code = SW_DOWN;
    end
    return code;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser plus a saturating debounce counter.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   raw          - raw asynchronous switch pin
//   stable       - currently published debounced level for this bit
//   commit       - the top accepts this bit's new level this cycle
//   s            - synchronised level
//   ready        - synchronised level has differed from stable long enough
module sw_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic stable,
  input  logic commit,
  output logic s,
  output logic ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Synchroniser shift and counter update.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (commit || (sync2_q == stable)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s     = sync2_q;
  // Saturated counter stays pending while the top is in HOLD.
  assign ready = (cnt_q == CNT_MAX) && (sync2_q != stable);

endmodule

// File: rtl/sw_debounce_sync.sv
// Synchronises and debounces the slide switches and publishes the stable
// level SW together with SW_History, which is held at the pre-change value
// for HOLD_CYCLES after every accepted change so the round-robin scanner
// sees each changed bit once.
// Ports:
//   CLK, RESET       - clock, asynchronous active-high reset
//   SW_RAW           - raw switch pins
//   SW               - debounced switch levels
//   SW_History       - SW before the latest change while holding, else SW
//   SW_Change_Pulse  - one-cycle pulse when SW updates
//   SW_Change_Mask   - bits changed in that update (0 without the pulse)
//   Hold_Busy        - high while SW_History is being held
module sw_debounce_sync
  import sw_io_pkg::*;
#(
  parameter int unsigned N_SW            = N_SW_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned HOLD_CYCLES     = 12
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_SW-1:0] SW_RAW,
  output logic [N_SW-1:0] SW,
  output logic [N_SW-1:0] SW_History,
  output logic            SW_Change_Pulse,
  output logic [N_SW-1:0] SW_Change_Mask,
  output logic            Hold_Busy
);

  localparam int unsigned H_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  sw_state_e       state_q, state_d;
  logic [H_W-1:0]  h_q,     h_d;
  logic [N_SW-1:0] sw_q,    sw_d;
  logic [N_SW-1:0] hist_q,  hist_d;
  logic            pulse_q, pulse_d;
  logic [N_SW-1:0] mask_q,  mask_d;
  logic            busy_q,  busy_d;

  logic [N_SW-1:0] s_w;
  logic [N_SW-1:0] ready_w;
  logic [N_SW-1:0] commit_w;

  // Per-bit synchroniser and debounce counter.
  for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk   (CLK),
      .rst   (RESET),
      .raw   (SW_RAW[gi]),
      .stable(sw_q[gi]),
      .commit(commit_w[gi]),
      .s     (s_w[gi]),
      .ready (ready_w[gi])
    );
  end

  // Next-state and output logic: commits only from IDLE.
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    sw_d     = sw_q;
    hist_d   = hist_q;
    pulse_d  = 1'b0;
    mask_d   = '0;
    commit_w = '0;
    case (state_q)
      ST_IDLE: begin
        if (|ready_w) begin
          commit_w = ready_w;
          sw_d     = (sw_q & ~ready_w) | (s_w & ready_w);
          hist_d   = sw_q;
          mask_d   = ready_w;
          pulse_d  = 1'b1;
          h_d      = H_W'(HOLD_CYCLES - 1);
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (h_q == '0) begin
          hist_d  = sw_q;
          state_d = ST_IDLE;
        end else begin
          h_d = h_q - H_W'(1);
        end
      end
    endcase
    busy_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      sw_q    <= '0;
      hist_q  <= '0;
      pulse_q <= 1'b0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      sw_q    <= sw_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
    end
  end

  assign SW              = sw_q;
  assign SW_History      = hist_q;
  assign SW_Change_Pulse = pulse_q;
  assign SW_Change_Mask  = mask_q;
  assign Hold_Busy       = busy_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with DEBOUNCE_CYCLES=4, HOLD_CYCLES=12.
// Edge numbering: inputs are driven 1 time unit after edge e and outputs are
// sampled 1 time unit after edge e, so a raw change driven at edge t shows on
// SW at edge t+6.
module tb_sw_debounce_sync;

  localparam int unsigned NSW = 10;

  logic           clk;
  logic           rst;
  logic [NSW-1:0] sw_raw;
  logic [NSW-1:0] sw;
  logic [NSW-1:0] sw_hist;
  logic           pulse;
  logic [NSW-1:0] mask;
  logic           busy;

  int n_cmp;
  int n_fail;
  int cyc;

  sw_debounce_sync #(
    .N_SW           (NSW),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .HOLD_CYCLES    (12)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .SW_RAW         (sw_raw),
    .SW             (sw),
    .SW_History     (sw_hist),
    .SW_Change_Pulse(pulse),
    .SW_Change_Mask (mask),
    .Hold_Busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             e;
    logic [NSW-1:0] raw;
    logic [NSW-1:0] sw;
    logic [NSW-1:0] hist;
    logic           p;
    logic [NSW-1:0] m;
    logic           b;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [NSW-1:0] act,
                     input logic [NSW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [NSW-1:0] e_sw,
                         input logic [NSW-1:0] e_hist, input logic e_p,
                         input logic [NSW-1:0] e_m, input logic e_b);
    chk({tag, ".sw"},   sw,                 e_sw);
    chk({tag, ".hist"}, sw_hist,            e_hist);
    chk({tag, ".pulse"}, {9'd0, pulse},     {9'd0, e_p});
    chk({tag, ".mask"}, mask,               e_m);
    chk({tag, ".busy"}, {9'd0, busy},       {9'd0, e_b});
  endtask

  vec_t tv[$];
  int   r;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    rst    = 1'b1;
    sw_raw = '0;

    // Reset state.
    tick();
    tick();
    chk_out("reset", 10'h000, 10'h000, 1'b0, 10'h000, 1'b0);
    rst = 1'b0;
    cyc = 0;

    // Clean rise of bit 3, bit 2 rising during HOLD, then a bit-5 glitch.
    tv.push_back('{10, 10'h008, 10'h000, 10'h000, 1'b0, 10'h000, 1'b0});
    tv.push_back('{15, 10'h008, 10'h000, 10'h000, 1'b0, 10'h000, 1'b0});
    tv.push_back('{16, 10'h008, 10'h008, 10'h000, 1'b1, 10'h008, 1'b1});
    tv.push_back('{17, 10'h008, 10'h008, 10'h000, 1'b0, 10'h000, 1'b1});
    tv.push_back('{19, 10'h00C, 10'h008, 10'h000, 1'b0, 10'h000, 1'b1});
    tv.push_back('{25, 10'h00C, 10'h008, 10'h000, 1'b0, 10'h000, 1'b1});
    tv.push_back('{27, 10'h00C, 10'h008, 10'h000, 1'b0, 10'h000, 1'b1});
    tv.push_back('{28, 10'h00C, 10'h008, 10'h008, 1'b0, 10'h000, 1'b0});
    tv.push_back('{29, 10'h00C, 10'h00C, 10'h008, 1'b1, 10'h004, 1'b1});
    tv.push_back('{30, 10'h00C, 10'h00C, 10'h008, 1'b0, 10'h000, 1'b1});
    tv.push_back('{40, 10'h00C, 10'h00C, 10'h008, 1'b0, 10'h000, 1'b1});
    tv.push_back('{41, 10'h00C, 10'h00C, 10'h00C, 1'b0, 10'h000, 1'b0});
    tv.push_back('{45, 10'h02C, 10'h00C, 10'h00C, 1'b0, 10'h000, 1'b0});
    tv.push_back('{48, 10'h00C, 10'h00C, 10'h00C, 1'b0, 10'h000, 1'b0});
    tv.push_back('{50, 10'h00C, 10'h00C, 10'h00C, 1'b0, 10'h000, 1'b0});
    tv.push_back('{51, 10'h00C, 10'h00C, 10'h00C, 1'b0, 10'h000, 1'b0});
    tv.push_back('{52, 10'h00C, 10'h00C, 10'h00C, 1'b0, 10'h000, 1'b0});
    tv.push_back('{56, 10'h00C, 10'h00C, 10'h00C, 1'b0, 10'h000, 1'b0});

    foreach (tv[i]) begin
      while (cyc < tv[i].e) tick();
      chk_out($sformatf("vec%0d", i), tv[i].sw, tv[i].hist, tv[i].p,
              tv[i].m, tv[i].b);
      sw_raw = tv[i].raw;
    end

    // Reset asserted from IDLE clears SW immediately.
    rst    = 1'b1;
    sw_raw = '0;
    #1;
    chk_out("rst_idle", 10'h000, 10'h000, 1'b0, 10'h000, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    r   = cyc;

    // Simultaneous rise of bits 0 and 9 gives one pulse with a 2-bit mask.
    sw_raw = 10'h201;
    while (cyc < r + 5) tick();
    chk_out("simul_pre", 10'h000, 10'h000, 1'b0, 10'h000, 1'b0);
    tick();
    chk_out("simul", 10'h201, 10'h000, 1'b1, 10'h201, 1'b1);
    tick();
    chk_out("simul_post", 10'h201, 10'h000, 1'b0, 10'h000, 1'b1);

    // Switch already high at reset release is accepted as an Up change.
    rst    = 1'b1;
    sw_raw = 10'h008;
    tick();
    tick();
    rst = 1'b0;
    r   = cyc;
    while (cyc < r + 5) tick();
    chk_out("rel_pre", 10'h000, 10'h000, 1'b0, 10'h000, 1'b0);
    tick();
    chk_out("rel_up", 10'h008, 10'h000, 1'b1, 10'h008, 1'b1);

    // Reset on HOLD cycle 5, then re-commit 6 cycles after release.
    r = cyc;
    while (cyc < r + 4) tick();
    chk_out("hold5", 10'h008, 10'h000, 1'b0, 10'h000, 1'b1);
    rst = 1'b1;
    #1;
    chk_out("rst_hold", 10'h000, 10'h000, 1'b0, 10'h000, 1'b0);
    tick();
    chk_out("rst_hold_clk", 10'h000, 10'h000, 1'b0, 10'h000, 1'b0);
    rst = 1'b0;
    r   = cyc;
    while (cyc < r + 5) tick();
    chk_out("recommit_pre", 10'h000, 10'h000, 1'b0, 10'h000, 1'b0);
    tick();
    chk_out("recommit", 10'h008, 10'h000, 1'b1, 10'h008, 1'b1);

    // Fall of bit 3 after the hold window closes.
    r = cyc;
    while (cyc < r + 11) tick();
    chk_out("hold_last", 10'h008, 10'h000, 1'b0, 10'h000, 1'b1);
    tick();
    chk_out("hold_end", 10'h008, 10'h008, 1'b0, 10'h000, 1'b0);
    sw_raw = 10'h000;
    r      = cyc;
    while (cyc < r + 5) tick();
    chk_out("fall_pre", 10'h008, 10'h008, 1'b0, 10'h000, 1'b0);
    tick();
    chk_out("fall", 10'h000, 10'h008, 1'b1, 10'h008, 1'b1);
    tick();
    chk_out("fall_hold", 10'h000, 10'h008, 1'b0, 10'h000, 1'b1);
    r = cyc;
    while (cyc < r + 10) tick();
    chk_out("fall_last", 10'h000, 10'h008, 1'b0, 10'h000, 1'b1);
    tick();
    chk_out("fall_idle", 10'h000, 10'h000, 1'b0, 10'h000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
